// File: rtl/button_event_reporter.sv
// rtl/button_event_reporter.sv - debounced button press flags, counters and snapshots for host WireOut/TriggerOut
// Optional macro BTN_OVERFLOW_EN: saturating counters with sticky overflow flags (default: wrapping counters).
module button_event_reporter #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 8
) (
    input  logic                       ti_clk,
    input  logic                       reset,
    input  logic [N_BUTTONS-1:0]       button,
    input  logic                       ack_valid,
    input  logic [N_BUTTONS-1:0]       ack_mask,
    input  logic                       snapshot_req,
    output logic [N_BUTTONS-1:0]       press_pulse,
    output logic [15:0]                ep_status,
    output logic [N_BUTTONS*CNT_W-1:0] cnt_snapshot,
    output logic [N_BUTTONS-1:0]       ovf_flags
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync_q1;
    logic [N_BUTTONS-1:0] synced;
    logic [N_BUTTONS-1:0] stable;
    logic [N_BUTTONS-1:0] stable_d;
    logic [N_BUTTONS-1:0] sticky;
    logic [N_BUTTONS-1:0] press;
    logic [N_BUTTONS-1:0] ack_hit;
    logic [DW-1:0]        dcnt     [N_BUTTONS];
    logic [CNT_W-1:0]     press_cnt[N_BUTTONS];

    assign press   = stable & ~stable_d;
    assign ack_hit = ack_valid ? ack_mask : '0;

    // Inverting ahead of the flops keeps the cleared state equal to "released".
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            sync_q1 <= '0;
            synced  <= '0;
        end else begin
            sync_q1 <= ~button;
            synced  <= sync_q1;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (synced[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCNT_LAST) begin
                    stable[i] <= synced[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_OVERFLOW_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [N_BUTTONS-1:0] ovf_q;

    assign ovf_flags = ovf_q;
`else
    assign ovf_flags = '0;
`endif

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            stable_d     <= '0;
            press_pulse  <= '0;
            sticky       <= '0;
            cnt_snapshot <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                press_cnt[i] <= '0;
            end
`ifdef BTN_OVERFLOW_EN
            ovf_q <= '0;
`endif
        end else begin
            stable_d    <= stable;
            press_pulse <= press;
            sticky      <= (sticky & ~ack_hit) | press;
            for (int i = 0; i < N_BUTTONS; i++) begin
                // Snapshot sees the counter before this edge's press/ack.
                if (snapshot_req) begin
                    cnt_snapshot[i*CNT_W +: CNT_W] <= press_cnt[i];
                end
                if (ack_hit[i]) begin
                    press_cnt[i] <= press[i] ? CNT_W'(1) : '0;
`ifdef BTN_OVERFLOW_EN
                    ovf_q[i] <= 1'b0;
`endif
                end else if (press[i]) begin
`ifdef BTN_OVERFLOW_EN
                    if (press_cnt[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
                    end else begin
                        press_cnt[i] <= press_cnt[i] + 1'b1;
                    end
`else
                    press_cnt[i] <= press_cnt[i] + 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        ep_status = '0;
        ep_status[N_BUTTONS-1:0]  = sticky;
        ep_status[8 +: N_BUTTONS] = stable;
    end

endmodule

// File: tb/tb_button_event_reporter.sv
// tb/tb_button_event_reporter.sv - directed self-checking bench for button_event_reporter
module tb_button_event_reporter;

    logic        ti_clk = 1'b0;
    logic        reset;
    logic [3:0]  button;
    logic        ack_valid;
    logic [3:0]  ack_mask;
    logic        snapshot_req;
    logic [3:0]  press_pulse;
    logic [15:0] ep_status;
    logic [31:0] cnt_snapshot;
    logic [3:0]  ovf_flags;

    int vectors = 0;
    int errors  = 0;

    button_event_reporter #(
        .N_BUTTONS      (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .ti_clk      (ti_clk),
        .reset       (reset),
        .button      (button),
        .ack_valid   (ack_valid),
        .ack_mask    (ack_mask),
        .snapshot_req(snapshot_req),
        .press_pulse (press_pulse),
        .ep_status   (ep_status),
        .cnt_snapshot(cnt_snapshot),
        .ovf_flags   (ovf_flags)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge ti_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press_once(input int idx);
        button[idx] = 1'b0;
        tick(8);
        button[idx] = 1'b1;
        tick(8);
    endtask

    task automatic snapshot();
        snapshot_req = 1'b1;
        tick(1);
        snapshot_req = 1'b0;
    endtask

    task automatic ack(input logic [3:0] mask);
        ack_valid = 1'b1;
        ack_mask  = mask;
        tick(1);
        ack_valid = 1'b0;
        ack_mask  = 4'h0;
    endtask

    initial begin
        reset        = 1'b1;
        button       = 4'hF;
        ack_valid    = 1'b0;
        ack_mask     = 4'h0;
        snapshot_req = 1'b0;
        tick(2);
        check("reset_status", ep_status, 16'h0000);
        check("reset_pulse", press_pulse, 4'h0);
        check("reset_snapshot", cnt_snapshot, 32'h0);
        check("reset_ovf", ovf_flags, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_status", ep_status, 16'h0000);
            check("idle_pulse", press_pulse, 4'h0);
        end

        // Press latency: pulse on the 7th edge after the pin edge, exactly one cycle.
        button[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            check("b0_pulse_timing", press_pulse, (i == 7) ? 32'h1 : 32'h0);
        end
        check("b0_status", ep_status, 16'h0101);
        snapshot();
        check("b0_count", cnt_snapshot, 32'h0000_0001);

        // Bouncing button 1 never holds long enough.
        for (int t = 0; t < 10; t++) begin
            button[1] = ~button[1];
            tick(1);
            check("bounce_pulse", press_pulse, 4'h0);
            tick(1);
            check("bounce_pulse", press_pulse, 4'h0);
        end
        tick(8);
        check("bounce_status", ep_status, 16'h0101);
        button[0] = 1'b1;
        tick(8);
        check("b0_release_status", ep_status, 16'h0001);

        // Three presses on button 2, snapshot, then ack.
        for (int p = 0; p < 3; p++) press_once(2);
        check("b2_status", ep_status, 16'h0005);
        snapshot();
        check("b2_snapshot", cnt_snapshot, 32'h0003_0001);
        ack(4'b0100);
        check("b2_ack_status", ep_status, 16'h0001);
        check("b2_snapshot_hold", cnt_snapshot, 32'h0003_0001);
        ack_valid = 1'b1;
        ack_mask  = 4'h0;
        tick(1);
        ack_valid = 1'b0;
        ack_mask  = 4'hF;
        tick(1);
        ack_mask  = 4'h0;
        check("null_ack_status", ep_status, 16'h0001);
        snapshot();
        check("b2_snapshot_cleared", cnt_snapshot, 32'h0000_0001);

        // Press and ack land on the same edge for button 3.
        button[3] = 1'b0;
        tick(6);
        check("b3_pre_pulse", press_pulse, 4'h0);
        ack(4'b1000);
        check("b3_pulse", press_pulse, 4'b1000);
        check("b3_press_wins", ep_status, 16'h0809);
        snapshot();
        check("b3_count_one", cnt_snapshot, 32'h0100_0001);
        snapshot_req = 1'b1;
        ack(4'b1000);
        snapshot_req = 1'b0;
        check("snap_pre_ack", cnt_snapshot, 32'h0100_0001);
        check("b3_ack_status", ep_status, 16'h0801);
        snapshot();
        check("snap_post_ack", cnt_snapshot, 32'h0000_0001);
        button[3] = 1'b1;
        tick(8);

        // 256 presses on button 0 from a cleared counter.
        ack(4'b0001);
        check("b0_cleared_status", ep_status, 16'h0000);
        for (int p = 0; p < 256; p++) press_once(0);
        snapshot();
`ifdef BTN_OVERFLOW_EN
        check("b0_saturate", cnt_snapshot, 32'h0000_00FF);
        check("b0_ovf", ovf_flags, 4'b0001);
`else
        check("b0_wrap", cnt_snapshot, 32'h0000_0000);
        check("b0_ovf", ovf_flags, 4'b0000);
`endif
        ack(4'b0001);
        check("ovf_ack", ovf_flags, 4'b0000);

        // Reset mid-debounce restarts the full latency.
        button[1] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset2_status", ep_status, 16'h0000);
        check("reset2_snapshot", cnt_snapshot, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("reset_debounce_pulse", press_pulse, (i == 7) ? 32'h2 : 32'h0);
        end
        check("reset_debounce_status", ep_status, 16'h0202);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
